// File: rtl/inst_mem_responder_pkg.sv
// inst_mem_pkg: types and constants shared by the instruction-memory responder.
//   INST_W    instruction word width
//   ADDR_W    fetch / preload byte address width
//   IMEM_NOP  word returned for a rejected fetch (addi x0,x0,0)
//   imem_resp_t  one delay-line entry: valid strobe, error flag, instruction word
package inst_mem_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 64;
  localparam logic [INST_W-1:0] IMEM_NOP = 32'h0000_0013;

  typedef struct packed {
    logic              valid;
    logic              err;
    logic [INST_W-1:0] inst;
  } imem_resp_t;

endpackage

// File: rtl/inst_mem_responder_delay_line.sv
// imem_delay_line: LATENCY-stage shift register of fetch responses.
//   i_clk    core clock
//   i_rst    asynchronous active-high reset, clears every stage
//   i_flush  synchronous kill of all entries already in the line
//   i_resp   entry captured into stage 0 this edge
//   o_resp   last stage, registered output of the responder
module imem_delay_line
  import inst_mem_pkg::*;
#(
  parameter int LATENCY = 5
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_flush,
  input  imem_resp_t i_resp,
  output imem_resp_t o_resp
);

  imem_resp_t stage_q [LATENCY];

  // Payload only moves together with a live valid bit, so the last stage keeps
  // the previous response's inst/err while no new response is presented.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < LATENCY; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      // A request arriving with a flush is newer than the flush and survives.
      stage_q[0].valid <= i_resp.valid;
      if (i_resp.valid) begin
        stage_q[0].err  <= i_resp.err;
        stage_q[0].inst <= i_resp.inst;
      end
      for (int k = 1; k < LATENCY; k++) begin
        stage_q[k].valid <= stage_q[k-1].valid & ~i_flush;
        if (stage_q[k-1].valid && !i_flush) begin
          stage_q[k].err  <= stage_q[k-1].err;
          stage_q[k].inst <= stage_q[k-1].inst;
        end
      end
    end
  end

  assign o_resp = stage_q[LATENCY-1];

endmodule

// File: rtl/inst_mem_responder.sv
// inst_mem_responder: instruction memory answering IF fetches after a fixed latency.
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_valid_addr, i_addr         fetch request strobe and byte address
//   i_flush                      drop all in-flight responses
//   i_wr_en, i_wr_addr, i_wr_data  preload write port
//   o_valid_inst, o_inst         response strobe and instruction word
//   o_addr_err                   response belongs to a misaligned / out-of-range fetch
module inst_mem_responder
  import inst_mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid_addr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_flush,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [INST_W-1:0] i_wr_data,
  output logic              o_valid_inst,
  output logic [INST_W-1:0] o_inst,
  output logic              o_addr_err
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [INST_W-1:0] mem_q [DEPTH];

  logic             rd_ok;
  logic             wr_ok;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  imem_resp_t       line_in;
  imem_resp_t       line_out;

  // Everything above the word index must be zero across the full 64 bits, so
  // large addresses never alias back into the array.
  assign rd_ok  = (i_addr[1:0] == 2'b00) && ((i_addr >> (IDX_W + 2)) == '0);
  assign wr_ok  = (i_wr_addr[1:0] == 2'b00) && ((i_wr_addr >> (IDX_W + 2)) == '0);
  assign rd_idx = i_addr[IDX_W+1:2];
  assign wr_idx = i_wr_addr[IDX_W+1:2];

  always_ff @(posedge i_clk) begin
    if (i_wr_en && wr_ok) begin
      mem_q[wr_idx] <= i_wr_data;
    end
  end

  // The array value seen here is the pre-edge content, so a same-edge write
  // to the fetched word yields the old data.
  always_comb begin
    line_in       = '0;
    line_in.valid = i_valid_addr;
    line_in.err   = ~rd_ok;
    line_in.inst  = IMEM_NOP;
    if (rd_ok) begin
      line_in.inst = mem_q[rd_idx];
    end
  end

  imem_delay_line #(
    .LATENCY (LATENCY)
  ) u_delay_line (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_flush),
    .i_resp  (line_in),
    .o_resp  (line_out)
  );

  assign o_valid_inst = line_out.valid;
  assign o_inst       = line_out.inst;
  assign o_addr_err   = line_out.err;

endmodule

// File: tb/tb_inst_mem_responder.sv
// tb_inst_mem_responder: scoreboard bench for inst_mem_responder.
//   Stimulus pushes the expected response (word, error flag, due cycle) computed
//   from a plain array model; a negedge monitor pops and compares.
module tb_inst_mem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 5;
  localparam int IDXW  = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_addr = 1'b0;
  logic [63:0] addr = '0;
  logic        flush = 1'b0;
  logic        wr_en = 1'b0;
  logic [63:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        o_valid_inst;
  logic [31:0] o_inst;
  logic        o_addr_err;

  inst_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_valid_addr (valid_addr),
    .i_addr       (addr),
    .i_flush      (flush),
    .i_wr_en      (wr_en),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .o_valid_inst (o_valid_inst),
    .o_inst       (o_inst),
    .o_addr_err   (o_addr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [31:0] inst;
    int          due;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem_m [DEPTH];
  logic [31:0] last_inst = '0;
  logic        last_err  = 1'b0;
  int          errors = 0;
  int          checks = 0;

  function automatic logic addr_ok(input logic [63:0] a);
    return (a % 4 == 0) && (a < 64'(4 * DEPTH));
  endfunction

  // One clock of stimulus; the model is updated for the edge that follows.
  task automatic step(input logic v, input logic [63:0] a, input logic fl,
                      input logic we, input logic [63:0] wa, input logic [31:0] wd);
    exp_t e;
    exp_t keep[$];
    @(negedge clk);
    valid_addr = v; addr = a; flush = fl;
    wr_en = we; wr_addr = wa; wr_data = wd;
    if (fl) begin
      keep = {};
      foreach (q[i]) if (q[i].due < cyc + 1) keep.push_back(q[i]);
      q = keep;
    end
    if (v) begin
      e.err  = !addr_ok(a);
      e.inst = addr_ok(a) ? mem_m[a[IDXW+1:2]] : 32'h0000_0013;
      e.due  = cyc + LAT;
      q.push_back(e);
    end
    if (we && addr_ok(wa)) mem_m[wa[IDXW+1:2]] = wd;
  endtask

  task automatic req(input logic [63:0] a);
    step(1'b1, a, 1'b0, 1'b0, 64'd0, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 32'd0);
  endtask

  // Assert reset mid-cycle, away from the monitor's sampling point.
  task automatic do_reset();
    @(negedge clk);
    valid_addr = 1'b0; flush = 1'b0; wr_en = 1'b0;
    #2;
    rst = 1'b1;
    q = {};
    last_inst = '0;
    last_err  = 1'b0;
    #1;
    checks++;
    if (o_valid_inst !== 1'b0 || o_inst !== 32'd0 || o_addr_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b inst=%h err=%b required 0/00000000/0",
               o_valid_inst, o_inst, o_addr_err);
    end
    idle(2);
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].due < cyc) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_resp: no response seen by cycle %0d, required inst=%h err=%b",
               e.due, e.inst, e.err);
    end
    checks++;
    if (o_valid_inst === 1'b1) begin
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp: cycle %0d inst=%h err=%b, required no response",
                 cyc, o_inst, o_addr_err);
      end else begin
        e = q.pop_front();
        if (e.due != cyc || o_inst !== e.inst || o_addr_err !== e.err) begin
          errors++;
          $display("FAIL response: cycle %0d inst=%h err=%b, required cycle %0d inst=%h err=%b",
                   cyc, o_inst, o_addr_err, e.due, e.inst, e.err);
        end
        last_inst = e.inst;
        last_err  = e.err;
      end
    end else if (o_valid_inst !== 1'b0 || o_inst !== last_inst || o_addr_err !== last_err) begin
      errors++;
      $display("FAIL hold: cycle %0d valid=%b inst=%h err=%b, required 0/%h/%b",
               cyc, o_valid_inst, o_inst, o_addr_err, last_inst, last_err);
    end
  end

  initial begin
    logic [63:0] a;
    logic [63:0] wa;
    int          r;

    // Reset state before any clocking activity.
    #1;
    checks++;
    if (o_valid_inst !== 1'b0 || o_inst !== 32'd0 || o_addr_err !== 1'b0) begin
      errors++;
      $display("FAIL initial_reset: valid=%b inst=%h err=%b required 0/00000000/0",
               o_valid_inst, o_inst, o_addr_err);
    end
    idle(2);
    @(negedge clk);
    rst = 1'b0;

    // Preload: words 0..3 fixed, the rest random.
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, 64'd0, 1'b0, 1'b1, 64'(i * 4),
           (i < 4) ? 32'((i + 1) * 32'h11) : $urandom);
    idle(1);

    // Single fetch.
    req(64'd0);
    idle(LAT + 1);
    // Back-to-back fetches.
    req(64'd0); req(64'd4); req(64'd8); req(64'd12);
    idle(LAT + 1);
    // Rejected addresses.
    req(64'd2); req(64'(4 * DEPTH)); req(64'h1_0000_0000);
    idle(LAT + 1);
    // Same-edge write and read returns old data, next read the new word.
    step(1'b1, 64'd4, 1'b0, 1'b1, 64'd4, 32'h0000_00AA);
    req(64'd4);
    idle(LAT + 1);
    // Flush with a simultaneous request.
    req(64'd0); req(64'd4); req(64'd8);
    step(1'b1, 64'd12, 1'b1, 1'b0, 64'd0, 32'd0);
    idle(LAT + 1);
    // Reset with responses in flight; contents survive.
    req(64'd0); req(64'd4); req(64'd8);
    do_reset();
    req(64'd0);
    idle(LAT + 1);
    // Bad write addresses are dropped.
    step(1'b0, 64'd0, 1'b0, 1'b1, 64'd9, 32'hDEAD_BEEF);
    step(1'b0, 64'd0, 1'b0, 1'b1, 64'(4 * DEPTH), 32'hDEAD_BEEF);
    req(64'd8); req(64'd0);
    idle(LAT + 1);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 80)      a = 64'($urandom_range(0, DEPTH - 1)) * 4;
      else if (r < 90) a = 64'($urandom_range(0, 4 * DEPTH - 1)) | 64'd1;
      else             a = 64'(4 * DEPTH) + {32'($urandom), 32'($urandom)} % 64'h1_0000_0000_0000;
      r = $urandom_range(0, 99);
      wa = (r < 85) ? 64'($urandom_range(0, DEPTH - 1)) * 4
                    : {32'($urandom), 32'($urandom)};
      step($urandom_range(0, 99) < 60, a, $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 10, wa, $urandom);
    end
    idle(LAT + 2);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, required 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
